// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter and its round-robin picker.
// Holds the requester count and index names, the ROB tag / data widths
// and a helper that sizes pointer/index fields.
package cdb_arbiter_pkg;

  // Default number of CDB requesters (load/store, ALU, branch, spare).
  localparam int CDB_REQ_NUM = 4;

  // Width of a reorder-buffer tag; tag 0 is reserved for "no dependency".
  localparam int ROB_WIDTH = 5;

  // Width of a result value.
  localparam int ID_WIDTH = 32;

  // Requester slots on the bus; load/store sits at index 0 so that it
  // wins under fixed priority.
  typedef enum logic [1:0] {
    CDB_LSB   = 2'd0,
    CDB_ALU   = 2'd1,
    CDB_BRU   = 2'd2,
    CDB_SPARE = 2'd3
  } cdb_req_e;

  // Width of a binary index into n requesters (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotate-and-priority-encode picker: starting at index 'start', returns
// the first set bit of 'valid' (wrapping) as a one-hot grant and a binary
// index. Purely combinational; also used by the reservation-station
// issue select. 'start' must be below N.
module rr_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int N = CDB_REQ_NUM,
  parameter int W = ptr_width(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] start,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);

  // Scan start, start+1, ... modulo N and take the first valid slot.
  always_comb begin
    logic done;
    int   j;
    grant = '0;
    idx   = '0;
    done  = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!done && valid[j]) begin
        grant[j] = 1'b1;
        idx      = W'(j);
        done     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one functional-unit result per cycle
// (round-robin by default) and broadcasts it one cycle later through a
// registered tag/value/valid stage. A flush kills the next broadcast.
// Build option: define CDB_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins, rotating pointer removed).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NREQ = CDB_REQ_NUM
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic [NREQ-1:0]          req_valid_in,
  input  logic [NREQ*ROB_WIDTH-1:0] req_tag_in,
  input  logic [NREQ*ID_WIDTH-1:0]  req_value_in,
  output logic [NREQ-1:0]          grant_out,
  output logic                     cdb_valid_out,
  output logic [ROB_WIDTH-1:0]     cdb_tag_out,
  output logic [ID_WIDTH-1:0]      cdb_value_out
);

  localparam int PW = ptr_width(NREQ);

  logic [NREQ-1:0]      tag_nz;
  logic [NREQ-1:0]      eligible;
  logic [NREQ-1:0]      pick_grant;
  logic [PW-1:0]        pick_idx;
  logic                 grant_en;
  logic                 any_grant;
  logic [PW-1:0]        ptr_reg;
  logic                 cdb_valid_reg;
  logic [ROB_WIDTH-1:0] cdb_tag_reg;
  logic [ID_WIDTH-1:0]  cdb_value_reg;

  // A request carrying tag 0 would look like "no dependency" to the
  // consumers, so such a request is never eligible.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_tag_nz
      assign tag_nz[gi] = |req_tag_in[gi*ROB_WIDTH +: ROB_WIDTH];
    end
  endgenerate

  assign eligible = req_valid_in & tag_nz;
  assign grant_en = rdy_in && !flush_in && !rst_in;

  rr_picker #(
    .N (NREQ),
    .W (PW)
  ) u_picker (
    .valid (eligible),
    .start (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign grant_out = grant_en ? pick_grant : '0;
  assign any_grant = |grant_out;

`ifdef CDB_ARB_FIXED_PRIO_EN
  // Fixed priority: the scan always starts at requester 0.
  assign ptr_reg = '0;
`else
  // Rotate the priority pointer to just past the winner.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr_reg <= '0;
    end else if (rdy_in && !flush_in && any_grant) begin
      ptr_reg <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
`endif

  // Broadcast register: load the winner, drop valid on flush or idle,
  // freeze everything while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_valid_reg <= 1'b0;
      cdb_tag_reg   <= '0;
      cdb_value_reg <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        cdb_valid_reg <= 1'b0;
      end else if (any_grant) begin
        cdb_valid_reg <= 1'b1;
        cdb_tag_reg   <= req_tag_in[pick_idx*ROB_WIDTH +: ROB_WIDTH];
        cdb_value_reg <= req_value_in[pick_idx*ID_WIDTH +: ID_WIDTH];
      end else begin
        cdb_valid_reg <= 1'b0;
      end
    end
  end

  assign cdb_valid_out = cdb_valid_reg;
  assign cdb_tag_out   = cdb_tag_reg;
  assign cdb_value_out = cdb_value_reg;

  // Flag requesters that present a valid result with the reserved tag 0.
  assert property (@(posedge clk_in) disable iff (rst_in)
                   !(|(req_valid_in & ~tag_nz)))
    else $warning("cdb_arbiter: valid request with ROB tag 0, mask %b",
                  req_valid_in & ~tag_nz);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a behavioural model predicts the
// same-cycle grant and the next-cycle broadcast; predicted broadcasts are
// queued at drive time and compared after the clock edge.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = CDB_REQ_NUM;
  localparam int RW = ROB_WIDTH;
  localparam int VW = ID_WIDTH;

  typedef struct packed {
    logic          v;
    logic [RW-1:0] t;
    logic [VW-1:0] d;
  } bcast_t;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            rdy_in;
  logic            flush_in;
  logic [N-1:0]    req_valid_in;
  logic [N*RW-1:0] req_tag_in;
  logic [N*VW-1:0] req_value_in;
  logic [N-1:0]    grant_out;
  logic            cdb_valid_out;
  logic [RW-1:0]   cdb_tag_out;
  logic [VW-1:0]   cdb_value_out;

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(.NREQ(N)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .flush_in      (flush_in),
    .req_valid_in  (req_valid_in),
    .req_tag_in    (req_tag_in),
    .req_value_in  (req_value_in),
    .grant_out     (grant_out),
    .cdb_valid_out (cdb_valid_out),
    .cdb_tag_out   (cdb_tag_out),
    .cdb_value_out (cdb_value_out)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  int            m_ptr   = 0;
  bcast_t        m_cdb   = '0;
  bcast_t        exp_q[$];
  logic [RW-1:0] tg[N];
  logic [VW-1:0] vl[N];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference pick: first requester from 'start' (wrapping) that is valid
  // and carries a nonzero tag; -1 if none.
  function automatic int model_pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (v[j] && tg[j] != '0) return j;
    end
    return -1;
  endfunction

  // One bus cycle: drive at the falling edge, check the grant, queue the
  // predicted broadcast, then compare it after the rising edge.
  task automatic step(input logic rst, input logic rdy, input logic flush,
                      input logic [N-1:0] v, input string name);
    int           p;
    int           start;
    logic [N-1:0] eg;
    bcast_t       e;
    @(negedge clk_in);
    rst_in       = rst;
    rdy_in       = rdy;
    flush_in     = flush;
    req_valid_in = v;
    for (int i = 0; i < N; i++) begin
      req_tag_in[i*RW +: RW]   = tg[i];
      req_value_in[i*VW +: VW] = vl[i];
    end
    #1;
`ifdef CDB_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    p  = (rst || !rdy || flush) ? -1 : model_pick(v, start);
    eg = '0;
    if (p >= 0) eg[p] = 1'b1;
    chk({name, "_grant"}, 64'(grant_out), 64'(eg));
    if (rst) begin
      m_cdb = '0;
      m_ptr = 0;
    end else if (rdy) begin
      if (flush) begin
        m_cdb.v = 1'b0;
      end else if (p >= 0) begin
        m_cdb = '{v: 1'b1, t: tg[p], d: vl[p]};
        m_ptr = (p + 1) % N;
      end else begin
        m_cdb.v = 1'b0;
      end
    end
    exp_q.push_back(m_cdb);
    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    chk({name, "_valid"}, 64'(cdb_valid_out), 64'(e.v));
    chk({name, "_tag"},   64'(cdb_tag_out),   64'(e.t));
    chk({name, "_value"}, 64'(cdb_value_out), 64'(e.d));
    $display("[TB] %s: rst=%0b rdy=%0b flush=%0b req=%b grant=%b cdb=%0b/%0h/%h",
             name, rst, rdy, flush, v, grant_out, cdb_valid_out, cdb_tag_out, cdb_value_out);
  endtask

  initial begin
    rst_in       = 1'b1;
    rdy_in       = 1'b1;
    flush_in     = 1'b0;
    req_valid_in = '0;
    req_tag_in   = '0;
    req_value_in = '0;
    for (int i = 0; i < N; i++) begin
      tg[i] = RW'(10 + i);
      vl[i] = 32'h1000_0000 + 32'(i);
    end

    // Reset, including requests presented during reset (no grant allowed).
    step(1'b1, 1'b1, 1'b0, '0,       "reset0");
    step(1'b1, 1'b1, 1'b0, 4'b1111,  "reset1");

    // Single request from requester 1.
    tg[1] = 5;
    vl[1] = 32'hDEAD_BEEF;
    step(1'b0, 1'b1, 1'b0, 4'b0010, "single");
    step(1'b0, 1'b1, 1'b0, 4'b0000, "idle");

    // All four held valid for 8 cycles starting from ptr=0.
    step(1'b1, 1'b1, 1'b0, 4'b0000, "rst_rr");
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) vl[i] = $urandom;
      step(1'b0, 1'b1, 1'b0, 4'b1111, $sformatf("rr%0d", c));
    end

    // Flush with every requester valid.
    step(1'b0, 1'b1, 1'b1, 4'b1111, "flush");
    step(1'b0, 1'b1, 1'b0, 4'b0000, "post_flush");

    // Broadcast tag 7, then freeze for 3 cycles and resume.
    tg[0] = 7;
    step(1'b0, 1'b1, 1'b0, 4'b0001, "tag7");
    for (int c = 0; c < 3; c++)
      step(1'b0, 1'b0, 1'b0, 4'b1111, $sformatf("stall%0d", c));
    step(1'b0, 1'b1, 1'b0, 4'b1111, "resume");

    // Illegal tag 0 on slice 2 alongside a legal request on slice 3.
    tg[2] = '0;
    tg[3] = 9;
    step(1'b0, 1'b1, 1'b0, 4'b1100, "tag0");
    tg[2] = 12;
    step(1'b0, 1'b1, 1'b0, 4'b0000, "tag0_clr");

    // Reset in the middle of back-to-back grants.
    step(1'b0, 1'b1, 1'b0, 4'b1111, "b2b0");
    step(1'b0, 1'b1, 1'b0, 4'b1111, "b2b1");
    step(1'b1, 1'b1, 1'b0, 4'b1111, "b2b_rst");
    step(1'b0, 1'b1, 1'b0, 4'b1111, "post_rst");

    // Random traffic with occasional stalls and flushes.
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++) begin
        tg[i] = RW'($urandom_range(1, (1 << RW) - 1));
        vl[i] = $urandom;
      end
      step(1'b0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
           N'($urandom_range(0, (1 << N) - 1)), $sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
